// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle between an upstream requester and div_issue_ctrl.
// The master side is the requester; the slave side is the controller.
interface div_issue_ctrl_if #(
  parameter int unsigned N     = 21,
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_q;
  logic [N-1:0]     rsp_r;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;

  modport master (
    output req_valid, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_tag, rsp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_tag, rsp_dz
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Front-end for the multi-cycle unsigned divider: issues one tagged request at a time,
// resolves divide-by-zero locally, buffers one response and watches for a hung divider.
module div_issue_ctrl #(
  parameter int unsigned N       = 21,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  div_issue_ctrl_if.slave   io,
  output logic              div_en,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic              div_done,
  input  logic [N-1:0]      div_q,
  input  logic [N-1:0]      div_r,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       op_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [15:0]      op_cnt_q, op_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_q_q, rsp_q_d;
  logic [N-1:0]     rsp_r_q, rsp_r_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic req_ready_c;
  logic accept;

  // Stale div_done from the previous operation must never overlap a new issue.
  assign req_ready_c = rst_n && (state_q == S_IDLE) && !div_done
                       && (!rsp_valid_q || io.rsp_ready);
  assign accept      = io.req_valid && req_ready_c;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    op_cnt_d    = op_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_q_d     = rsp_q_q;
    rsp_r_d     = rsp_r_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_dz_d    = rsp_dz_q;

    // A pop frees the slot; a fill later in this block overrides it.
    if (rsp_valid_q && io.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (io.req_b != '0) begin
            a_d     = io.req_a;
            b_d     = io.req_b;
            tag_d   = io.req_tag;
            state_d = S_ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_q_d     = '1;
            rsp_r_d     = io.req_a;
            rsp_tag_d   = io.req_tag;
            rsp_dz_d    = 1'b1;
            op_cnt_d    = op_cnt_q + 16'd1;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          rsp_valid_d = 1'b1;
          rsp_q_d     = div_q;
          rsp_r_d     = div_r;
          rsp_tag_d   = tag_q;
          rsp_dz_d    = 1'b0;
          op_cnt_d    = op_cnt_q + 16'd1;
          wait_cnt_d  = '0;
          state_d     = S_IDLE;
        end else if (wait_cnt_q != CW'(TIMEOUT)) begin
          // Counter saturates at TIMEOUT; the flag rises as it gets there.
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      op_cnt_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      op_cnt_q    <= op_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_r_q     <= rsp_r_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_dz_q    <= rsp_dz_d;
    end
  end

  assign io.req_ready = req_ready_c;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_q     = rsp_q_q;
  assign io.rsp_r     = rsp_r_q;
  assign io.rsp_tag   = rsp_tag_q;
  assign io.rsp_dz    = rsp_dz_q;

  assign div_en      = (state_q == S_ISSUE);
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign op_cnt      = op_cnt_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider stub (2N+4 latency, 2-cycle stale done).
module tb_div_issue_ctrl;
  localparam int unsigned N       = 21;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned LAT     = 2 * N + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.N(N), .TAG_W(TAG_W)) io ();

  logic             div_en;
  logic [N-1:0]     div_a;
  logic [N-1:0]     div_b;
  logic             div_done;
  logic [N-1:0]     div_q;
  logic [N-1:0]     div_r;
  logic             busy;
  logic             err_timeout;
  logic [15:0]      op_cnt;

  div_issue_ctrl #(.N(N), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .div_en     (div_en),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_q      (div_q),
    .div_r      (div_r),
    .busy       (busy),
    .err_timeout(err_timeout),
    .op_cnt     (op_cnt)
  );

  // Divider stub: done first reads 1 LAT cycles after the en cycle, then stays high 2 cycles.
  logic        stub_hang;
  logic        dv_run;
  int unsigned dv_cnt;
  int unsigned dv_hold;
  always @(posedge clk) begin
    if (!rst_n) begin
      dv_run   <= 1'b0;
      dv_cnt   <= 0;
      dv_hold  <= 0;
      div_done <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (div_en) begin
      dv_run <= 1'b1;
      dv_cnt <= 1;
      div_q  <= div_a / div_b;
      div_r  <= div_a % div_b;
    end else if (dv_run) begin
      if (dv_cnt == LAT - 1) begin
        if (!stub_hang) begin
          div_done <= 1'b1;
          dv_hold  <= 2;
          dv_run   <= 1'b0;
        end
      end else begin
        dv_cnt <= dv_cnt + 1;
      end
    end else if (div_done) begin
      if (dv_hold <= 1) div_done <= 1'b0;
      dv_hold <= dv_hold - 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!io.rsp_valid && n < 200) begin
      step();
      n++;
    end
  endtask

  int           n;
  int           overlap;
  int           bad_stable;
  int           stray;
  logic         saw_stale;
  logic         got1;
  logic         accepted2;
  logic [N-1:0] snap_q;
  logic [N-1:0] snap_r;
  logic [3:0]   snap_tag;

  initial begin
    rst_n        = 1'b0;
    stub_hang    = 1'b0;
    io.req_valid = 1'b0;
    io.req_a     = '0;
    io.req_b     = '0;
    io.req_tag   = '0;
    io.rsp_ready = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_rsp_valid", 32'(io.rsp_valid), 0);
    chk("rst_req_ready", 32'(io.req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_en", 32'(div_en), 0);
    chk("rst_op_cnt", 32'(op_cnt), 0);
    rst_n = 1'b1;
    step();

    // Basic divide 100/7 tag 3
    io.req_valid = 1'b1;
    io.req_a = 21'd100; io.req_b = 21'd7; io.req_tag = 4'd3;
    #1;
    chk("basic_req_ready", 32'(io.req_ready), 1);
    step();
    io.req_valid = 1'b0;
    chk("basic_div_en", 32'(div_en), 1);
    chk("basic_div_a", 32'(div_a), 100);
    chk("basic_div_b", 32'(div_b), 7);
    chk("basic_busy", 32'(busy), 1);
    wait_rsp(n);
    chk("basic_latency", 32'(n), 47);
    chk("basic_q", 32'(io.rsp_q), 14);
    chk("basic_r", 32'(io.rsp_r), 2);
    chk("basic_tag", 32'(io.rsp_tag), 3);
    chk("basic_dz", 32'(io.rsp_dz), 0);
    chk("basic_op_cnt", 32'(op_cnt), 1);
    repeat (3) step();

    // Divide by zero 0x1234/0 tag 5
    io.req_valid = 1'b1;
    io.req_a = 21'h1234; io.req_b = '0; io.req_tag = 4'd5;
    #1;
    chk("dz_req_ready", 32'(io.req_ready), 1);
    step();
    io.req_valid = 1'b0;
    chk("dz_div_en", 32'(div_en), 0);
    chk("dz_busy", 32'(busy), 0);
    chk("dz_valid", 32'(io.rsp_valid), 1);
    chk("dz_q", 32'(io.rsp_q), 32'h1FFFFF);
    chk("dz_r", 32'(io.rsp_r), 32'h1234);
    chk("dz_flag", 32'(io.rsp_dz), 1);
    chk("dz_tag", 32'(io.rsp_tag), 5);
    chk("dz_op_cnt", 32'(op_cnt), 2);
    step();
    chk("dz_popped", 32'(io.rsp_valid), 0);

    // Back-to-back 50/5 tag 1 then 9/4 tag 2 with stale done
    io.req_valid = 1'b1;
    io.req_a = 21'd50; io.req_b = 21'd5; io.req_tag = 4'd1;
    step();
    io.req_a = 21'd9; io.req_b = 21'd4; io.req_tag = 4'd2;
    #1;
    n = 0; overlap = 0; saw_stale = 1'b0; got1 = 1'b0; accepted2 = 1'b0;
    while (!accepted2 && n < 200) begin
      if (io.rsp_valid && !got1) begin
        got1 = 1'b1;
        chk("b2b_q1", 32'(io.rsp_q), 10);
        chk("b2b_r1", 32'(io.rsp_r), 0);
        chk("b2b_tag1", 32'(io.rsp_tag), 1);
      end
      if (div_done && io.req_ready) overlap++;
      if (div_done && !busy) saw_stale = 1'b1;
      if (io.req_ready) accepted2 = 1'b1;
      step();
      n++;
    end
    io.req_valid = 1'b0;
    chk("b2b_accepted2", 32'(accepted2), 1);
    chk("b2b_got1", 32'(got1), 1);
    chk("b2b_saw_stale", 32'(saw_stale), 1);
    chk("b2b_overlap", 32'(overlap), 0);
    chk("b2b_div_en2", 32'(div_en), 1);
    chk("b2b_div_a2", 32'(div_a), 9);
    chk("b2b_done_low", 32'(div_done), 0);
    wait_rsp(n);
    chk("b2b_q2", 32'(io.rsp_q), 2);
    chk("b2b_r2", 32'(io.rsp_r), 1);
    chk("b2b_tag2", 32'(io.rsp_tag), 2);
    chk("b2b_op_cnt", 32'(op_cnt), 4);
    step();

    // Backpressure: hold response 20 cycles with a pending request
    io.rsp_ready = 1'b0;
    repeat (3) step();
    io.req_valid = 1'b1;
    io.req_a = 21'd100; io.req_b = 21'd10; io.req_tag = 4'd7;
    step();
    io.req_valid = 1'b0;
    wait_rsp(n);
    chk("bp_q", 32'(io.rsp_q), 10);
    chk("bp_tag", 32'(io.rsp_tag), 7);
    snap_q = io.rsp_q; snap_r = io.rsp_r; snap_tag = io.rsp_tag;
    io.req_valid = 1'b1;
    io.req_a = 21'd20; io.req_b = '0; io.req_tag = 4'd8;
    bad_stable = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (io.req_ready !== 1'b0 || io.rsp_valid !== 1'b1 || io.rsp_q !== snap_q ||
          io.rsp_r !== snap_r || io.rsp_tag !== snap_tag || io.rsp_dz !== 1'b0)
        bad_stable++;
      step();
    end
    chk("bp_stable", 32'(bad_stable), 0);
    io.rsp_ready = 1'b1;
    #1;
    chk("bp_same_cycle_ready", 32'(io.req_ready), 1);
    step();
    io.req_valid = 1'b0;
    chk("bp_refill_valid", 32'(io.rsp_valid), 1);
    chk("bp_refill_r", 32'(io.rsp_r), 20);
    chk("bp_refill_tag", 32'(io.rsp_tag), 8);
    chk("bp_refill_dz", 32'(io.rsp_dz), 1);
    step();
    chk("bp_drained", 32'(io.rsp_valid), 0);
    chk("bp_op_cnt", 32'(op_cnt), 6);

    // Timeout with a divider that never completes
    stub_hang = 1'b1;
    io.req_valid = 1'b1;
    io.req_a = 21'd30; io.req_b = 21'd3; io.req_tag = 4'd9;
    step();
    io.req_valid = 1'b0;
    step();
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n), TIMEOUT);
    repeat (10) step();
    chk("to_sticky", 32'(err_timeout), 1);
    chk("to_busy", 32'(busy), 1);
    chk("to_no_rsp", 32'(io.rsp_valid), 0);

    // Reset in WAIT cycle 20, then a fresh request
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    stub_hang = 1'b0;
    io.req_valid = 1'b1;
    io.req_a = 21'd77; io.req_b = 21'd8; io.req_tag = 4'd4;
    step();
    io.req_valid = 1'b0;
    step();
    repeat (20) step();
    chk("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    step();
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rsp_valid", 32'(io.rsp_valid), 0);
    chk("mid_err", 32'(err_timeout), 0);
    chk("mid_div_a", 32'(div_a), 0);
    chk("mid_req_ready", 32'(io.req_ready), 0);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (io.rsp_valid !== 1'b0) stray++;
    end
    chk("mid_no_stray_rsp", 32'(stray), 0);
    io.req_valid = 1'b1;
    step();
    io.req_valid = 1'b0;
    wait_rsp(n);
    chk("fresh_q", 32'(io.rsp_q), 9);
    chk("fresh_r", 32'(io.rsp_r), 5);
    chk("fresh_tag", 32'(io.rsp_tag), 4);
    chk("fresh_op_cnt", 32'(op_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
